// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and one holding register per lane.
// Optional per-lane transfer counters are enabled by defining DEMUX1TO4_STATS_EN.
module demux1to4_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic               auto_en,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
`ifdef DEMUX1TO4_STATS_EN
  output logic [31:0]        lane_cnt,
`endif
  output logic [1:0]         ptr
);

  logic [4*WIDTH-1:0] data_q, data_d;
  logic [3:0]         valid_q, valid_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         dest;
  logic               xfer;
  logic [3:0]         load;

  assign dest     = auto_en ? ptr_q : sel;
  assign in_ready = ~valid_q[dest] | out_ready[dest];
  assign xfer     = in_valid & in_ready;

  always_comb begin
    load    = 4'b0000;
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < 4; k++) begin
      load[k] = xfer && (dest == 2'(k));
      // A lane stays full if refilled, or if its consumer has not taken the word yet.
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
      if (load[k]) begin
        data_d[k*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && auto_en) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
      ptr_q   <= 2'b00;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign ptr       = ptr_q;

`ifdef DEMUX1TO4_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (load[k] && (cnt_q[k*8 +: 8] != 8'hff)) begin
        cnt_d[k*8 +: 8] = cnt_q[k*8 +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lane_cnt = cnt_q;
`endif

endmodule
